// File: rtl/card_dealer_pkg.sv
// rtl/card_dealer_pkg.sv - shared types and constants for the card dealer.
package card_dealer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_PRESENT
  } state_t;

  localparam logic [5:0]  DECK_SIZE    = 6'd52;
  localparam logic [5:0]  RANKS        = 6'd13;
  localparam logic [3:0]  LFSR_INIT_HI = 4'hA;
  // Feedback taps at bits 15, 13, 12, 10.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/card_dealer_decode.sv
// rtl/card_dealer_decode.sv - card_decode: deck index to rank, suit and blackjack points.
module card_decode
  import card_dealer_pkg::*;
(
  input  logic [5:0] index,
  output logic [3:0] rank,
  output logic [1:0] suit,
  output logic [3:0] points
);

  logic [5:0] rem;

  always_comb begin
    suit = 2'd0;
    rem  = index;
    if (index >= RANKS * 6'd3) begin
      suit = 2'd3;
      rem  = index - RANKS * 6'd3;
    end else if (index >= RANKS * 6'd2) begin
      suit = 2'd2;
      rem  = index - RANKS * 6'd2;
    end else if (index >= RANKS) begin
      suit = 2'd1;
      rem  = index - RANKS;
    end
    rank = rem[3:0] + 4'd1;
    if (rank == 4'd1)
      points = 4'd11;
    else if (rank > 4'd10)
      points = 4'd10;
    else
      points = rank;
  end

endmodule

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - LFSR-driven card dealer; CARD_DEALER_DEDUP_EN enables a no-repeat 52-card deck.
module card_dealer
  import card_dealer_pkg::*;
#(
  parameter int SEED_W = 12
) (
  input  logic              clk_50M,
  input  logic              i_Reset_n,
  input  logic [SEED_W-1:0] i_Seed,
  input  logic              i_Shuffle,
  input  logic              i_DrawReq,
  input  logic              i_CardAck,
  output logic              o_CardValid,
  output logic [3:0]        o_Rank,
  output logic [1:0]        o_Suit,
  output logic [3:0]        o_Points,
  output logic [5:0]        o_CardsLeft,
  output logic              o_DeckEmpty,
  output logic              o_Busy
);

  state_t      state;
  logic [15:0] lfsr;
  logic [5:0]  cand;
  logic        accept;
  logic [3:0]  dec_rank;
  logic [1:0]  dec_suit;
  logic [3:0]  dec_points;

  assign cand = lfsr[5:0];

  card_decode u_decode (
    .index  (cand),
    .rank   (dec_rank),
    .suit   (dec_suit),
    .points (dec_points)
  );

`ifdef CARD_DEALER_DEDUP_EN
  logic [DECK_SIZE-1:0] bitmap;
  logic [5:0]           cards_left;

  assign accept      = (cand < DECK_SIZE) && !bitmap[cand];
  assign o_CardsLeft = cards_left;
  assign o_DeckEmpty = (cards_left == 6'd0);

  always_ff @(posedge clk_50M or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      bitmap     <= '0;
      cards_left <= DECK_SIZE;
    end else if (i_Shuffle) begin
      bitmap     <= '0;
      cards_left <= DECK_SIZE;
    end else if (state == ST_SEARCH && accept) begin
      bitmap[cand] <= 1'b1;
      cards_left   <= cards_left - 6'd1;
    end
  end
`else
  assign accept      = (cand < DECK_SIZE);
  assign o_CardsLeft = DECK_SIZE;
  assign o_DeckEmpty = 1'b0;
`endif

  always_ff @(posedge clk_50M or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state       <= ST_IDLE;
      lfsr        <= {LFSR_INIT_HI, 12'h000};
      o_CardValid <= 1'b0;
      o_Rank      <= 4'd0;
      o_Suit      <= 2'd0;
      o_Points    <= 4'd0;
      o_Busy      <= 1'b0;
    end else if (i_Shuffle) begin
      // Shuffle overrides any draw or ack arriving in the same cycle.
      state       <= ST_IDLE;
      lfsr        <= {LFSR_INIT_HI, i_Seed[11:0]};
      o_CardValid <= 1'b0;
      o_Busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_DrawReq && !o_DeckEmpty) begin
            state  <= ST_SEARCH;
            o_Busy <= 1'b1;
          end
        end
        ST_SEARCH: begin
          lfsr <= lfsr_next(lfsr);
          if (accept) begin
            o_Rank      <= dec_rank;
            o_Suit      <= dec_suit;
            o_Points    <= dec_points;
            o_CardValid <= 1'b1;
            state       <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (i_CardAck) begin
            o_CardValid <= 1'b0;
            o_Busy      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - scoreboard bench for card_dealer, both CARD_DEALER_DEDUP_EN builds.
module tb_card_dealer;

  logic        clk_50M = 1'b0;
  logic        i_Reset_n;
  logic [11:0] i_Seed;
  logic        i_Shuffle, i_DrawReq, i_CardAck;
  logic        o_CardValid, o_DeckEmpty, o_Busy;
  logic [3:0]  o_Rank, o_Points;
  logic [1:0]  o_Suit;
  logic [5:0]  o_CardsLeft;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    int rank;
    int suit;
    int points;
    int lat;
    int idx;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] m_lfsr;
  logic [51:0] m_bitmap;
  int          m_left;

  card_dealer #(.SEED_W(12)) dut (
    .clk_50M     (clk_50M),
    .i_Reset_n   (i_Reset_n),
    .i_Seed      (i_Seed),
    .i_Shuffle   (i_Shuffle),
    .i_DrawReq   (i_DrawReq),
    .i_CardAck   (i_CardAck),
    .o_CardValid (o_CardValid),
    .o_Rank      (o_Rank),
    .o_Suit      (o_Suit),
    .o_Points    (o_Points),
    .o_CardsLeft (o_CardsLeft),
    .o_DeckEmpty (o_DeckEmpty),
    .o_Busy      (o_Busy)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic chk(input string tag, input int act, input int exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic void m_shuffle(input logic [11:0] seed);
    m_lfsr   = {4'hA, seed};
    m_bitmap = '0;
    m_left   = 52;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    int   c;
    bit   ok;
    e.lat = 0;
    c = 0;
    for (int k = 0; k < 70000; k++) begin
      c = int'(m_lfsr[5:0]);
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      e.lat++;
`ifdef CARD_DEALER_DEDUP_EN
      ok = (c < 52) && !m_bitmap[c];
`else
      ok = (c < 52);
`endif
      if (ok) break;
    end
    e.idx    = c;
    e.rank   = c % 13 + 1;
    e.suit   = c / 13;
    e.points = (e.rank == 1) ? 11 : (e.rank > 10 ? 10 : e.rank);
`ifdef CARD_DEALER_DEDUP_EN
    m_bitmap[c] = 1'b1;
    m_left--;
`endif
    return e;
  endfunction

  task automatic shuffle(input logic [11:0] seed);
    i_Seed    = seed;
    i_Shuffle = 1'b1;
    @(posedge clk_50M);
    #1 i_Shuffle = 1'b0;
    m_shuffle(seed);
  endtask

  task automatic draw(output exp_t e, output int lat);
    exp_t p;
    p = predict();
    sbq.push_back(p);
    i_DrawReq = 1'b1;
    @(posedge clk_50M);
    #1 i_DrawReq = 1'b0;
    lat = 0;
    while (!o_CardValid && lat < 2000) begin
      @(posedge clk_50M);
      #1 lat++;
    end
    e = sbq.pop_front();
    if (!o_CardValid) begin
      chk("draw_timeout", 0, 1);
      return;
    end
    chk("rank", int'(o_Rank), e.rank);
    chk("suit", int'(o_Suit), e.suit);
    chk("points", int'(o_Points), e.points);
    chk("latency", lat, e.lat);
    chk("cards_left", int'(o_CardsLeft), m_left);
    chk("busy_present", int'(o_Busy), 1);
  endtask

  task automatic ack();
    i_CardAck = 1'b1;
    @(posedge clk_50M);
    #1 i_CardAck = 1'b0;
    chk("valid_after_ack", int'(o_CardValid), 0);
    chk("busy_after_ack", int'(o_Busy), 0);
  endtask

  initial begin
    exp_t        e;
    int          lat;
    int          idx;
    logic [51:0] seen;

    i_Reset_n = 1'b0;
    i_Seed    = '0;
    i_Shuffle = 1'b0;
    i_DrawReq = 1'b0;
    i_CardAck = 1'b0;
    m_shuffle(12'h000);
    repeat (3) @(posedge clk_50M);
    #1;
    chk("rst_valid", int'(o_CardValid), 0);
    chk("rst_rank", int'(o_Rank), 0);
    chk("rst_suit", int'(o_Suit), 0);
    chk("rst_points", int'(o_Points), 0);
    chk("rst_busy", int'(o_Busy), 0);
    chk("rst_empty", int'(o_DeckEmpty), 0);
    chk("rst_left", int'(o_CardsLeft), 52);
    i_Reset_n = 1'b1;
    @(posedge clk_50M);
    #1;

    // Seed 0: first candidate (index 0, Ace of suit 0) accepted immediately.
    shuffle(12'h000);
    draw(e, lat);
    chk("s0_lat", lat, 1);
    chk("s0_rank", int'(o_Rank), 1);
    chk("s0_points", int'(o_Points), 11);
    ack();

    // Seed 03F: four rejects then index 50; hold presentation 10 cycles.
    shuffle(12'h03F);
    draw(e, lat);
    chk("s3f_lat", lat, 5);
    chk("s3f_rank", int'(o_Rank), 12);
    chk("s3f_suit", int'(o_Suit), 3);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_50M);
      #1;
      chk("hold_valid", int'(o_CardValid), 1);
      chk("hold_rank", int'(o_Rank), e.rank);
      chk("hold_suit", int'(o_Suit), e.suit);
      chk("hold_points", int'(o_Points), e.points);
    end
    ack();

    // Shuffle during SEARCH aborts the draw.
    shuffle(12'h03F);
    i_DrawReq = 1'b1;
    @(posedge clk_50M);
    #1 i_DrawReq = 1'b0;
    i_Shuffle = 1'b1;
    @(posedge clk_50M);
    #1 i_Shuffle = 1'b0;
    m_shuffle(12'h03F);
    chk("shs_valid", int'(o_CardValid), 0);
    chk("shs_busy", int'(o_Busy), 0);
    chk("shs_left", int'(o_CardsLeft), 52);
    draw(e, lat);
    chk("shs_redraw_lat", lat, 5);

    // Shuffle coincident with ack wins.
    i_CardAck = 1'b1;
    i_Shuffle = 1'b1;
    @(posedge clk_50M);
    #1;
    i_CardAck = 1'b0;
    i_Shuffle = 1'b0;
    m_shuffle(12'h03F);
    chk("sha_valid", int'(o_CardValid), 0);
    chk("sha_busy", int'(o_Busy), 0);
    chk("sha_left", int'(o_CardsLeft), 52);
    draw(e, lat);
    ack();

    // Reset mid-SEARCH discards the card in progress.
    i_DrawReq = 1'b1;
    @(posedge clk_50M);
    #1 i_DrawReq = 1'b0;
    i_Reset_n = 1'b0;
    #3;
    chk("rsts_valid", int'(o_CardValid), 0);
    chk("rsts_busy", int'(o_Busy), 0);
    chk("rsts_left", int'(o_CardsLeft), 52);
    @(posedge clk_50M);
    #1 i_Reset_n = 1'b1;
    m_shuffle(12'h000);
    draw(e, lat);
    ack();

`ifdef CARD_DEALER_DEDUP_EN
    // Deal the whole deck from a random seed.
    shuffle(12'($urandom));
    seen = '0;
    for (int n = 0; n < 52; n++) begin
      draw(e, lat);
      idx = int'(o_Suit) * 13 + int'(o_Rank) - 1;
      if (idx >= 0 && idx < 52) begin
        chk("unique", int'(seen[idx]), 0);
        seen[idx] = 1'b1;
      end else begin
        chk("index_range", idx, e.idx);
      end
      ack();
    end
    chk("all_dealt", int'(&seen), 1);
    chk("exh_left", int'(o_CardsLeft), 0);
    chk("exh_empty", int'(o_DeckEmpty), 1);
    i_DrawReq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_50M);
      #1;
      chk("exh_valid", int'(o_CardValid), 0);
      chk("exh_busy", int'(o_Busy), 0);
    end
    i_DrawReq = 1'b0;
`else
    // Infinite deck: count never moves.
    shuffle(12'h000);
    for (int n = 0; n < 2; n++) begin
      draw(e, lat);
      ack();
    end
    chk("inf_left", int'(o_CardsLeft), 52);
    chk("inf_empty", int'(o_DeckEmpty), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
